rr_arbiter_fsm: RTL and testbench

//  Round-robin arbiter FSM. Shares one resource (a datapath unit, a bus slave or a

---
 rtl/rr_arbiter_fsm_if.sv | 33 +++
 rtl/rr_arbiter_fsm.sv | 135 +++++++++++++
 tb/tb_rr_arbiter_fsm.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_fsm_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
// Latency: none (wires only).
// Backpressure: requests are level-held by the requester until its grant is used.
// Ports: req (requesters -> arbiter), gnt/gnt_id/busy/timeout (arbiter -> requesters).
interface rr_arbiter_fsm_if #(
    parameter int N = 4
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] gnt_id;
    logic            busy;
    logic            timeout;

    // Requester side drives requests and observes the grant state.
    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  timeout
    );

    // Arbiter side consumes requests and drives the grant state.
    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output busy,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter_fsm.sv
// Round-robin arbiter: one owner at a time, bounded tenure, idle gap between owners.
// Latency: grant appears on the edge after a request is seen (registered Moore outputs).
// Backpressure: requests stay pending until granted; non-owner requests are not latched.
// Ports: clk, reset_n (async, active-low), bus (slave modport: req in; gnt, gnt_id,
//        busy, timeout out).
module rr_arbiter_fsm #(
    parameter int N          = 4,
    parameter int MAX_HOLD   = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    rr_arbiter_fsm_if.slave   bus
);
    localparam int ID_W   = (N > 1) ? $clog2(N) : 1;
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        gnt_q, gnt_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic                to_q, to_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [3:0]          gap_q, gap_d;

    logic                win_vld;
    logic [ID_W-1:0]     win_id;

    // Winner search starts just after the previous owner, so the owner whose
    // tenure just ended is considered last and only wins if nobody else asks.
    always_comb begin : rr_pick
        int              idx;
        logic [ID_W-1:0] cand;
        win_vld = 1'b0;
        win_id  = last_q;
        idx     = 0;
        cand    = '0;
        for (int i = 1; i <= N; i++) begin
            idx  = (int'(last_q) + i) % N;
            cand = ID_W'(idx);
            if (!win_vld && bus.req[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        last_d  = last_q;
        to_d    = 1'b0;
        hold_d  = hold_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = GRANT;
                    gnt_d   = N'(1) << win_id;
                    id_d    = win_id;
                    hold_d  = HOLD_W'(1);
                end
            end
            GRANT: begin
                // Release is checked first so a release on the final allowed
                // cycle never raises timeout.
                if (!bus.req[id_q]) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    last_d  = id_q;
                    gap_d   = '0;
                end else if (MAX_HOLD != 0 && hold_q == HOLD_W'(MAX_HOLD)) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    last_d  = id_q;
                    gap_d   = '0;
                    to_d    = 1'b1;
                end else if (hold_q != '1) begin
                    // Saturates when unlimited so the counter never wraps.
                    hold_d = hold_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q >= 4'(GAP_CYCLES - 1)) begin
                    if (win_vld) begin
                        state_d = GRANT;
                        gnt_d   = N'(1) << win_id;
                        id_d    = win_id;
                        hold_d  = HOLD_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            last_q  <= ID_W'(N - 1);
            to_q    <= 1'b0;
            hold_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
            to_q    <= to_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = id_q;
    assign bus.busy    = |gnt_q;
    assign bus.timeout = to_q;
endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Bench for rr_arbiter_fsm: four instances with different hold/gap settings share one
// request vector; a tenure-level model predicts every output each cycle, and directed
// sequences pin hand-computed grant patterns.
module tb_rr_arbiter_fsm;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    localparam int MH_P[4] = '{16, 4, 0, 3};
    localparam int GP_P[4] = '{1, 1, 3, 1};

    logic [3:0] o_gnt[4];
    logic [1:0] o_id[4];
    logic       o_busy[4];
    logic       o_to[4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        rr_arbiter_fsm_if #(.N(4)) bus ();
        assign bus.req   = req;
        assign o_gnt[g]  = bus.gnt;
        assign o_id[g]   = bus.gnt_id;
        assign o_busy[g] = bus.busy;
        assign o_to[g]   = bus.timeout;
        rr_arbiter_fsm #(
            .N(4), .MAX_HOLD(MH_P[g]), .GAP_CYCLES(GP_P[g])
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .bus(bus)
        );
    end

    // Tenure-level model: who owns the resource, for how long, how much gap is left.
    typedef struct packed {
        int   owner;   // -1 when nobody holds the resource
        int   held;    // cycles of the current tenure so far
        int   gap;     // gap cycles still to run (0 = not in a gap)
        int   last;    // owner of the most recently finished tenure
        int   id;      // most recently granted index
        logic to;
    } m_t;

    m_t ms[4];

    function automatic m_t m_reset();
        m_t r;
        r.owner = -1; r.held = 0; r.gap = 0; r.last = 3; r.id = 0; r.to = 1'b0;
        return r;
    endfunction

    function automatic m_t m_step(m_t s, logic [3:0] r, int mh, int gp);
        m_t n = s;
        n.to = 1'b0;
        if (s.owner >= 0) begin
            if (!r[s.owner] || (mh != 0 && s.held == mh)) begin
                n.to    = r[s.owner];
                n.last  = s.owner;
                n.owner = -1;
                n.gap   = gp;
            end else begin
                n.held = s.held + 1;
            end
            return n;
        end
        if (s.gap > 1) begin
            n.gap = s.gap - 1;
            return n;
        end
        n.gap = 0;
        for (int k = 1; k <= 4; k++) begin
            int i = (s.last + k) % 4;
            if (r[i]) begin
                n.owner = i; n.held = 1; n.id = i;
                return n;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) ms[k] <= m_reset();
        end else begin
            for (int k = 0; k < 4; k++) ms[k] <= m_step(ms[k], req, MH_P[k], GP_P[k]);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                logic [3:0] eg;
                eg = (ms[k].owner >= 0) ? 4'(1 << ms[k].owner) : 4'b0000;
                chk($sformatf("model dut%0d gnt", k), 32'(o_gnt[k]), 32'(eg));
                chk($sformatf("model dut%0d gnt_id", k), 32'(o_id[k]), 32'(ms[k].id));
                chk($sformatf("model dut%0d busy", k), 32'(o_busy[k]), 32'(ms[k].owner >= 0));
                chk($sformatf("model dut%0d timeout", k), 32'(o_to[k]), 32'(ms[k].to));
            end
        end
    end

    task automatic pulse_reset();
        reset_n = 1'b0;
        req     = 4'b0000;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 4'b0000;
        repeat (2) @(negedge clk);
        chk_en  = 1'b1;
        reset_n = 1'b1;

        // Asynchronous reset in the middle of a tenure, then first grant after it.
        req = 4'b0100;
        repeat (3) @(negedge clk);
        chk("t1 gnt before reset", 32'(o_gnt[0]), 32'h4);
        #2 reset_n = 1'b0;
        #1;
        chk("t1 gnt in reset", 32'(o_gnt[0]), 32'h0);
        chk("t1 busy in reset", 32'(o_busy[0]), 32'h0);
        chk("t1 gnt_id in reset", 32'(o_id[0]), 32'h0);
        chk("t1 dut1 gnt in reset", 32'(o_gnt[1]), 32'h0);
        @(negedge clk);
        req     = 4'b1010;
        reset_n = 1'b1;
        @(negedge clk);
        chk("t1 first gnt", 32'(o_gnt[0]), 32'h2);
        chk("t1 first gnt_id", 32'(o_id[0]), 32'h1);

        // Single requester holds for five cycles then releases.
        req = 4'b0000;
        repeat (5) @(negedge clk);
        req = 4'b0100;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("t2 gnt cycle %0d", c), 32'(o_gnt[0]), 32'h4);
        end
        req = 4'b0000;
        @(negedge clk);
        chk("t2 gnt cycle 6", 32'(o_gnt[0]), 32'h0);
        chk("t2 busy cycle 6", 32'(o_busy[0]), 32'h0);
        chk("t2 gnt_id held", 32'(o_id[0]), 32'h2);
        @(negedge clk);
        chk("t2 gnt cycle 7", 32'(o_gnt[0]), 32'h0);

        // All four requesting with MAX_HOLD=4: rotate 0,1,2,3,0 with timeouts.
        pulse_reset();
        req = 4'b1111;
        for (int c = 1; c <= 25; c++) begin
            int         p;
            logic [3:0] eg;
            @(negedge clk);
            p  = (c - 1) % 5;
            eg = (p < 4) ? 4'(1 << (((c - 1) / 5) % 4)) : 4'b0000;
            chk($sformatf("t3 gnt cycle %0d", c), 32'(o_gnt[1]), 32'(eg));
            chk($sformatf("t3 timeout cycle %0d", c), 32'(o_to[1]), 32'(p == 4));
        end

        // Released owner re-requests during the gap alongside another requester.
        pulse_reset();
        req = 4'b0001;
        repeat (3) @(negedge clk);
        chk("t4 gnt owner0", 32'(o_gnt[0]), 32'h1);
        req = 4'b0000;
        @(negedge clk);
        chk("t4 gap", 32'(o_gnt[0]), 32'h0);
        req = 4'b0011;
        @(negedge clk);
        chk("t4 other wins", 32'(o_gnt[0]), 32'h2);
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        chk("t4 second gap", 32'(o_gnt[0]), 32'h0);
        @(negedge clk);
        chk("t4 owner0 again", 32'(o_gnt[0]), 32'h1);

        // Unlimited hold (dut2) and MAX_HOLD=3 self re-grant (dut3).
        pulse_reset();
        req = 4'b0001;
        for (int c = 1; c <= 100; c++) begin
            int p;
            @(negedge clk);
            p = (c - 1) % 4;
            chk($sformatf("t5 gnt cycle %0d", c), 32'(o_gnt[2]), 32'h1);
            chk($sformatf("t5 timeout cycle %0d", c), 32'(o_to[2]), 32'h0);
            chk($sformatf("t6 gnt cycle %0d", c), 32'(o_gnt[3]), 32'(p < 3));
            chk($sformatf("t6 timeout cycle %0d", c), 32'(o_to[3]), 32'(p == 3));
        end

        // Three-cycle gap on dut2: new request waits out the whole gap.
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        chk("t7 gap cycle 2", 32'(o_gnt[2]), 32'h0);
        @(negedge clk);
        chk("t7 gap cycle 3", 32'(o_gnt[2]), 32'h0);
        @(negedge clk);
        chk("t7 grant after gap", 32'(o_gnt[2]), 32'h2);
        chk("t7 gnt_id after gap", 32'(o_id[2]), 32'h1);

        req = 4'b0000;
        repeat (6) @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
